psum_relu_out: RTL and testbench



---
 rtl/psum_relu_out.sv | 132 +++++++++++++
 tb/tb_psum_relu_out.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/psum_relu_out.sv
// psum_relu_out: sums groups of LEN signed partial sums into one activation,
// applies ReLU, an arithmetic right shift and unsigned saturation to BW bits,
// and queues the results in a small circular FIFO with valid/ready output.
module psum_relu_out #(
   parameter int PSUM_BW = 16,
   parameter int BW      = 4,
   parameter int LEN     = 10,
   parameter int SHIFT   = 4,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PSUM_BW-1:0] in_psum,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BW-1:0]      out_data,
   output logic               sat_flag,
   output logic               busy
);

   // Four guard bits let up to 16 full-scale partial sums accumulate without wrap.
   localparam int ACCW = PSUM_BW + 4;
   localparam int CW   = (LEN > 1) ? $clog2(LEN) : 1;
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FW   = $clog2(DEPTH + 1);

   localparam logic [CW-1:0]   LAST_IDX = CW'(LEN - 1);
   localparam logic [ACCW-1:0] MAX_WIDE = ACCW'((1 << BW) - 1);
   localparam logic [BW-1:0]   MAX_OUT  = BW'((1 << BW) - 1);
   localparam logic [FW-1:0]   FULL_CNT = FW'(DEPTH);

   logic [ACCW-1:0] acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [FW-1:0]   count_q, count_d;
   logic [BW-1:0]   mem_q [DEPTH];
   logic            sat_q, sat_d;

   logic            accept;
   logic            isFinal;
   logic            push;
   logic            pop;
   logic [ACCW-1:0] psumExt;
   logic [ACCW-1:0] sum;
   logic [ACCW-1:0] reluVal;
   logic [ACCW-1:0] shifted;
   logic            clip;
   logic [BW-1:0]   resVal;

   // Handshake decode and the result datapath for the element being accepted.
   always_comb begin
      accept   = in_valid && in_ready;
      isFinal  = (cnt_q == LAST_IDX);
      push     = accept && isFinal;
      pop      = out_valid && out_ready;
      psumExt  = {{(ACCW - PSUM_BW){in_psum[PSUM_BW-1]}}, in_psum};
      sum      = acc_q + psumExt;
      reluVal  = sum[ACCW-1] ? '0 : sum;
      shifted  = reluVal >> SHIFT;
      clip     = (shifted > MAX_WIDE);
      resVal   = clip ? MAX_OUT : shifted[BW-1:0];
   end

   // Next-state for the accumulator, element counter, FIFO pointers and sticky flag.
   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      sat_d   = sat_q;
      if (accept) begin
         if (isFinal) begin
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
         end
      end
      if (push) begin
         wptr_d = wptr_q + PW'(1);
         sat_d  = sat_q | clip;
      end
      if (pop) begin
         rptr_d = rptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + FW'(1);
         2'b01:   count_d = count_q - FW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards any partial group and all queued results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         sat_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         sat_q   <= sat_d;
         if (push) begin
            mem_q[wptr_q] <= resVal;
         end
      end
   end

   // Outputs come from registered state only, so out_ready never reaches in_ready.
   always_comb begin
      in_ready  = (count_q < FULL_CNT);
      out_valid = (count_q != '0);
      out_data  = mem_q[rptr_q];
      sat_flag  = sat_q;
      busy      = (cnt_q != '0);
   end

endmodule

// File: tb/tb_psum_relu_out.sv
// tb_psum_relu_out: directed bench for psum_relu_out with one LEN=10 instance
// and one LEN=1 instance used for the continuous push/pop wrap sequence.
module tb_psum_relu_out;

   logic        clk;
   logic        reset;

   logic        inValid;
   logic        inReady;
   logic [15:0] inPsum;
   logic        outValid;
   logic        outReady;
   logic [3:0]  outData;
   logic        satFlag;
   logic        busy;

   logic        bInValid;
   logic        bInReady;
   logic [15:0] bInPsum;
   logic        bOutValid;
   logic        bOutReady;
   logic [3:0]  bOutData;
   logic        bSatFlag;
   logic        bBusy;

   int compared;
   int mismatched;

   psum_relu_out #(
      .PSUM_BW(16), .BW(4), .LEN(10), .SHIFT(4), .DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(inValid), .in_ready(inReady), .in_psum(inPsum),
      .out_valid(outValid), .out_ready(outReady), .out_data(outData),
      .sat_flag(satFlag), .busy(busy)
   );

   psum_relu_out #(
      .PSUM_BW(16), .BW(4), .LEN(1), .SHIFT(4), .DEPTH(4)
   ) dutLen1 (
      .clk(clk), .reset(reset),
      .in_valid(bInValid), .in_ready(bInReady), .in_psum(bInPsum),
      .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
      .sat_flag(bSatFlag), .busy(bBusy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] value);
      int waitCycles;
      waitCycles = 0;
      inValid = 1'b1;
      inPsum  = value;
      while (!inReady && waitCycles < 50) begin
         @(posedge clk); #1;
         waitCycles++;
      end
      if (!inReady) checkOutput("acceptTimeout", inReady, 1);
      @(posedge clk); #1;
      inValid = 1'b0;
   endtask

   task automatic applyGroup(input logic [15:0] value, input int n);
      for (int i = 0; i < n; i++) applyStimulus(value);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      inValid    = 1'b0;
      inPsum     = '0;
      outReady   = 1'b0;
      bInValid   = 1'b0;
      bInPsum    = '0;
      bOutReady  = 1'b0;

      #22;
      checkOutput("rstInReady", inReady, 1);
      checkOutput("rstOutValid", outValid, 0);
      checkOutput("rstOutData", outData, 0);
      checkOutput("rstSat", satFlag, 0);
      checkOutput("rstBusy", busy, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      $display("[TB] basic group 10..100 -> saturates to 15");
      outReady = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(16'(10 * i));
         if (i == 5) checkOutput("midBusy", busy, 1);
      end
      checkOutput("basicValid", outValid, 1);
      checkOutput("basicData", outData, 15);
      checkOutput("basicSat", satFlag, 1);
      checkOutput("basicBusy", busy, 0);
      @(posedge clk); #1;
      checkOutput("basicPopped", outValid, 0);

      $display("[TB] group of 3s -> 1, sticky sat");
      applyGroup(16'd3, 10);
      checkOutput("threesValid", outValid, 1);
      checkOutput("threesData", outData, 1);
      checkOutput("threesSat", satFlag, 1);
      @(posedge clk); #1;

      $display("[TB] negative group -> ReLU 0");
      applyGroup(16'hFFF6, 10);
      checkOutput("negValid", outValid, 1);
      checkOutput("negData", outData, 0);
      checkOutput("negSat", satFlag, 1);
      @(posedge clk); #1;

      $display("[TB] full-scale mixed group, sum -5");
      applyGroup(16'h8000, 5);
      applyGroup(16'h7FFF, 5);
      checkOutput("mixValid", outValid, 1);
      checkOutput("mixData", outData, 0);
      @(posedge clk); #1;
      checkOutput("mixPopped", outValid, 0);

      $display("[TB] backpressure: four groups fill the FIFO");
      outReady = 1'b0;
      applyGroup(16'd16, 40);
      checkOutput("fullInReady", inReady, 0);
      checkOutput("fullBusy", busy, 0);
      checkOutput("fullValid", outValid, 1);
      checkOutput("fullHead", outData, 10);
      inValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         inPsum = 16'(1000 + i);
         @(posedge clk); #1;
         checkOutput("stallInReady", inReady, 0);
         checkOutput("stallBusy", busy, 0);
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checkOutput("drainValid", outValid, 1);
         checkOutput("drainData", outData, 10);
         @(posedge clk); #1;
         if (k == 0) checkOutput("readyAfterPop", inReady, 1);
      end
      checkOutput("drainEmpty", outValid, 0);
      applyGroup(16'd16, 10);
      checkOutput("fifthValid", outValid, 1);
      checkOutput("fifthData", outData, 10);
      @(posedge clk); #1;
      checkOutput("fifthPopped", outValid, 0);

      $display("[TB] LEN=1 continuous push/pop across wrap");
      bOutReady = 1'b1;
      bInValid  = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         bInPsum = 16'(16 * i);
         @(posedge clk); #1;
         checkOutput("wrapValid", bOutValid, 1);
         checkOutput("wrapData", bOutData, 32'(i));
         checkOutput("wrapInReady", bInReady, 1);
      end
      bInValid = 1'b0;
      @(posedge clk); #1;
      checkOutput("wrapDrained", bOutValid, 0);
      checkOutput("wrapSat", bSatFlag, 0);
      checkOutput("wrapBusy", bBusy, 0);

      $display("[TB] pop on empty");
      outReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checkOutput("emptyValid", outValid, 0);
      end
      applyGroup(16'd8, 10);
      checkOutput("afterEmptyValid", outValid, 1);
      checkOutput("afterEmptyData", outData, 5);
      @(posedge clk); #1;

      $display("[TB] asynchronous reset mid-group with two queued");
      outReady = 1'b0;
      applyGroup(16'd16, 26);
      checkOutput("preRstBusy", busy, 1);
      checkOutput("preRstValid", outValid, 1);
      checkOutput("preRstSat", satFlag, 1);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("asyncValid", outValid, 0);
      checkOutput("asyncBusy", busy, 0);
      checkOutput("asyncSat", satFlag, 0);
      checkOutput("asyncInReady", inReady, 1);
      #2;
      reset = 1'b0;
      @(posedge clk); #1;
      outReady = 1'b1;
      applyGroup(16'd16, 10);
      checkOutput("postRstValid", outValid, 1);
      checkOutput("postRstData", outData, 10);
      checkOutput("postRstSat", satFlag, 0);
      @(posedge clk); #1;
      checkOutput("postRstSingle", outValid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
